// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 MIDI receiver with 3-sample majority voting and a valid/ready output stage.
// Define MIDI_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | line idle, waiting for a falling edge on din_s
//   ST_START | qualifying the start bit at its centre
//   ST_DATA  | sampling 8 data bits, LSB first
//   ST_STOP  | sampling the stop bit
//   ST_BREAK | stop bit was low; waiting for the line to return high
module midi_uart_rx #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       MIDI_DIN,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int MID          = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(MID + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             din_m;
    logic             din_s;
    logic             din_prev;
    logic             din_fall;

    logic [CNT_W-1:0] bit_cnt;
    logic             samp_a;
    logic             samp_b;
    logic             vote;
    logic             vote_tick;

    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic             shift_en;
    logic             byte_done;
    logic             stop_bad;

    // Reset-to-1 on the whole chain keeps a reset from looking like a start edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            din_m    <= 1'b1;
            din_s    <= 1'b1;
            din_prev <= 1'b1;
        end else begin
            din_m    <= MIDI_DIN;
            din_s    <= din_m;
            din_prev <= din_s;
        end
    end

    assign din_fall = din_prev & ~din_s;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bit_cnt <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
        end else begin
            if (state == ST_IDLE || state == ST_BREAK) begin
                bit_cnt <= '0;
            end else if (bit_cnt == CNT_LAST) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (bit_cnt == CNT_MID_M1) samp_a <= din_s;
            if (bit_cnt == CNT_MID)    samp_b <= din_s;
        end
    end

    assign vote      = (samp_a & samp_b) | (samp_a & din_s) | (samp_b & din_s);
    assign vote_tick = (bit_cnt == CNT_MID_P1);

    always_ff @(posedge sys_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (din_fall)  state_nxt = ST_START;
            ST_START: if (vote_tick) state_nxt = vote ? ST_IDLE : ST_DATA;
            ST_DATA:  if (vote_tick && bit_idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (vote_tick) state_nxt = vote ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (din_s)     state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            ST_DATA: shift_en = vote_tick;
            ST_STOP: begin
                byte_done = vote_tick & vote;
                stop_bad  = vote_tick & ~vote;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state == ST_START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) shift <= {vote, shift[7:1]};
            frame_err <= stop_bad;
        end
    end

`ifdef MIDI_RX_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full;
    logic             pop;
    logic             push;

    assign fifo_full = (count == DEPTH_C);
    assign pop       = (count != '0) & rx_ready;
    // A pop in the same cycle frees the slot the completing byte needs.
    assign push      = byte_done & (~fifo_full | pop);

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= byte_done & fifo_full & ~pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
                default: ;
            endcase
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
`else
    logic [7:0] hold;
    logic       hold_v;
    logic       pop;
    logic       push;

    assign pop  = hold_v & rx_ready;
    assign push = byte_done & (~hold_v | rx_ready);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hold    <= '0;
            hold_v  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= byte_done & hold_v & ~rx_ready;
            if (push) begin
                hold   <= shift;
                hold_v <= 1'b1;
            end else if (pop) begin
                hold_v <= 1'b0;
            end
        end
    end

    assign rx_valid = hold_v;
    assign rx_data  = hold;
`endif

endmodule

// File: tb/tb_midi_uart_rx.sv
// Scoreboard bench for midi_uart_rx, run at a reduced clock (64 clocks per bit) to keep runs short.
module tb_midi_uart_rx;

    localparam int CLK_HZ = 2000000;
    localparam int BAUD   = 31250;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int LAT_LO = (19 * CPB) / 2;
    localparam int LAT_HI = LAT_LO + 8;

    logic       sys_clk  = 1'b0;
    logic       rst      = 1'b1;
    logic       MIDI_DIN = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    midi_uart_rx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(4)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .MIDI_DIN (MIDI_DIN),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int         n_chk     = 0;
    int         n_err     = 0;
    logic [7:0] exp_q[$];
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         rise_cyc  = -1;
    int         start_cyc = 0;
    int         vlen      = 0;
    int         last_vlen = 0;
    logic       valid_d   = 1'b0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (rx_valid && !valid_d) rise_cyc = cyc;
            if (rx_valid) vlen++;
            else if (valid_d) begin
                last_vlen = vlen;
                vlen      = 0;
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() != 0) check_val("byte", rx_data, exp_q.pop_front());
                else                   check_val("unexpected_byte", rx_data, -1);
            end
            valid_d = rx_valid;
        end else begin
            valid_d = 1'b0;
            vlen    = 0;
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_v);
        start_cyc = cyc;
        MIDI_DIN  = 1'b0;
        idle(bc);
        for (int i = 0; i < 8; i++) begin
            MIDI_DIN = b[i];
            idle(bc);
        end
        MIDI_DIN = stop_v;
        idle(bc);
    endtask

    int fe_base;
    int ov_base;
    int lat;

    initial begin
        repeat (5) @(posedge sys_clk);
        #1;
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_frame_err", frame_err, 0);
        check_val("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(20);

        // 1: single byte, latency window
        exp_q.push_back(8'h90);
        send_byte(8'h90, CPB, 1'b1);
        idle(10);
        lat = rise_cyc - start_cyc;
        check_val("t1_latency_ok", int'(lat >= LAT_LO && lat <= LAT_HI), 1);
        check_val("t1_valid_len", last_vlen, 1);
        check_val("t1_drained", exp_q.size(), 0);

        // 2: short glitch is a false start
        fe_base  = fe_cnt;
        MIDI_DIN = 1'b0;
        idle(20);
        MIDI_DIN = 1'b1;
        idle(3 * CPB);
        check_val("t2_no_valid", rx_valid, 0);
        check_val("t2_no_fe", fe_cnt - fe_base, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, CPB, 1'b1);
        idle(10);
        check_val("t2_drained", exp_q.size(), 0);

        // 3: framing error followed by a long break
        fe_base = fe_cnt;
        send_byte(8'h45, CPB, 1'b0);
        idle(96 * CPB);
        MIDI_DIN = 1'b1;
        idle(2 * CPB);
        check_val("t3_fe_once", fe_cnt - fe_base, 1);
        exp_q.push_back(8'h7F);
        send_byte(8'h7F, CPB, 1'b1);
        idle(10);
        check_val("t3_drained", exp_q.size(), 0);
        check_val("t3_fe_total", fe_cnt - fe_base, 1);

        // 4: back-to-back bytes with the consumer stalled
        ov_base  = ov_cnt;
        rx_ready = 1'b0;
`ifdef MIDI_RX_FIFO_EN
        exp_q.push_back(8'h90);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h3C);
        send_byte(8'h90, CPB, 1'b1);
        send_byte(8'h40, CPB, 1'b1);
        send_byte(8'h7F, CPB, 1'b1);
        idle(5);
        check_val("t4_no_ov_yet", ov_cnt - ov_base, 0);
        send_byte(8'h3C, CPB, 1'b1);
        send_byte(8'h12, CPB, 1'b1);
        idle(10);
        check_val("t4_ov_count", ov_cnt - ov_base, 1);
`else
        exp_q.push_back(8'h90);
        send_byte(8'h90, CPB, 1'b1);
        send_byte(8'h40, CPB, 1'b1);
        send_byte(8'h7F, CPB, 1'b1);
        idle(10);
        check_val("t4_ov_count", ov_cnt - ov_base, 2);
`endif
        check_val("t4_hold_valid", rx_valid, 1);
        check_val("t4_hold_data", rx_data, 8'h90);
        rx_ready = 1'b1;
        idle(10);
        check_val("t4_drained", exp_q.size(), 0);
        check_val("t4_empty", rx_valid, 0);

        // 5: reset in the middle of data bit 4 of 0xAA
        ov_base  = ov_cnt;
        fe_base  = fe_cnt;
        MIDI_DIN = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            MIDI_DIN = 8'hAA >> i;
            idle(CPB);
        end
        MIDI_DIN = 1'b0;
        idle(CPB / 2);
        rst      = 1'b1;
        MIDI_DIN = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("t5_rst_valid", rx_valid, 0);
        check_val("t5_rst_data", rx_data, 0);
        check_val("t5_rst_fe", frame_err, 0);
        check_val("t5_rst_ov", overrun, 0);
        idle(3 * CPB);
        exp_q.push_back(8'h55);
        send_byte(8'h55, CPB, 1'b1);
        idle(10);
        check_val("t5_drained", exp_q.size(), 0);
        check_val("t5_no_fe", fe_cnt - fe_base, 0);

        // 6: bit-period jitter, short then long bits
        fe_base = fe_cnt;
        exp_q.push_back(8'hF0);
        send_byte(8'hF0, (CPB * 98 + 50) / 100, 1'b1);
        exp_q.push_back(8'hF0);
        send_byte(8'hF0, (CPB * 102 + 50) / 100, 1'b1);
        idle(10);
        check_val("t6_drained", exp_q.size(), 0);
        check_val("t6_no_fe", fe_cnt - fe_base, 0);
        check_val("end_no_ov", ov_cnt - ov_base, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want completion");
        n_err++;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
